// File: rtl/prog_mem.sv
// Program memory: single-port word store with a registered CPU read path and
// a byte-stream loader that fills memory from address 0 upward.
// The loader owns the write port while a session is active.
module prog_mem #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [15:0] toMem,
    output logic [15:0] fromMem,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        loading,
    output logic        load_done,
    output logic        load_err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
    // ptr is one bit wider than the memory index so it can reach DEPTH
    // after the final word without wrapping back onto word 0.
    localparam logic [AW:0] LAST_PTR = (AW + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        L_IDLE,
        L_HI,
        L_LO,
        L_WR,
        L_DONE
    } lstate_t;

    lstate_t      state_q, state_d;
    logic [AW:0]  ptr_q, ptr_d;
    logic [7:0]   hi_q, hi_d;
    logic [7:0]   lo_q, lo_d;
    logic         last_q, last_d;
    logic         err_q, err_d;
    logic [15:0]  rdata_q;

    logic [15:0]  mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;
    logic          addr_ok;

    // Out-of-range CPU addresses read as zero and never write.
    assign addr_ok = ({1'b0, addr} < DEPTH_W);

    // Loader next-state, handshake outputs and write-port arbitration.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        last_d     = last_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = addr[AW-1:0];
        mem_wdata  = toMem;
        load_ready = 1'b0;
        loading    = 1'b1;
        load_done  = 1'b0;

        case (state_q)
            L_IDLE: begin
                loading = 1'b0;
                // CPU owns the write port only outside a session.
                mem_we  = we && addr_ok;
                if (load_start) begin
                    state_d = L_HI;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            L_HI: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    if (load_last) begin
                        // Session ended on a high byte: odd byte count.
                        err_d   = 1'b1;
                        state_d = L_IDLE;
                    end else begin
                        hi_d    = load_data;
                        state_d = L_LO;
                    end
                end
            end
            L_LO: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    lo_d    = load_data;
                    last_d  = load_last;
                    state_d = L_WR;
                end
            end
            L_WR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q[AW-1:0];
                mem_wdata = {hi_q, lo_q};
                ptr_d     = ptr_q + 1'b1;
                if (last_q) begin
                    state_d = L_DONE;
                end else if (ptr_q == LAST_PTR) begin
                    // Memory full but the stream continues.
                    err_d   = 1'b1;
                    state_d = L_IDLE;
                end else begin
                    state_d = L_HI;
                end
            end
            L_DONE: begin
                load_done = 1'b1;
                state_d   = L_IDLE;
            end
            default: begin
                state_d = L_IDLE;
            end
        endcase
    end

    // Loader state registers; reset aborts any session in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= L_IDLE;
            ptr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read; a same-edge write is not forwarded, so old data returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= addr_ok ? mem[addr[AW-1:0]] : 16'h0000;
        end
    end

    assign fromMem  = rdata_q;
    assign load_err = err_q;

endmodule
